// File: rtl/calendar_date_feeder_pkg.sv
// Shared definitions for the calendar date feeder.
//   - Command codes driven on cmd_out towards the day stage.
//   - Sequencer state encoding.
//   - days_in_month(): Gregorian month length, leap rule included.
package calendar_date_feeder_pkg;

    localparam logic [7:0] CMD_NONE     = 8'h00;
    localparam logic [7:0] CMD_WR_YEAR  = 8'h05;
    localparam logic [7:0] CMD_WR_MONTH = 8'h09;
    localparam logic [7:0] CMD_WR_DATE  = 8'h0D;
    localparam logic [7:0] CMD_RD_DAY   = 8'h03;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_YEAR  = 3'd1,
        WR_MONTH = 3'd2,
        WR_DATE  = 3'd3,
        RD_DAY   = 3'd4,
        CAPTURE  = 3'd5
    } state_t;

    // Month values outside 1..12 fall into the 31-day default; callers
    // validate the month range separately.
    function automatic logic [4:0] days_in_month(input logic [15:0] y,
                                                 input logic [15:0] m);
        logic leap;
        leap = ((y[1:0] == 2'd0) && ((y % 16'd100) != 16'd0)) ||
               ((y % 16'd400) == 16'd0);
        case (m)
            16'd4, 16'd6, 16'd9, 16'd11: days_in_month = 5'd30;
            16'd2:                       days_in_month = leap ? 5'd29 : 5'd28;
            default:                     days_in_month = 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/calendar_date_feeder_if.sv
// Bus bundle of the calendar date feeder.
//   master: drives tick/load requests and returns day_in (software + day stage side)
//   slave : the feeder itself; drives command/data bus and date/status outputs
interface calendar_date_feeder_if;
    logic        day_tick;
    logic        load;
    logic [15:0] load_year;
    logic [15:0] load_month;
    logic [15:0] load_date;
    logic [7:0]  cmd_out;
    logic [15:0] data_out;
    logic [15:0] day_in;
    logic [15:0] year;
    logic [15:0] month;
    logic [15:0] date;
    logic [2:0]  day_of_week;
    logic        dow_valid;
    logic        busy;
    logic        load_err;

    modport master (
        output day_tick, load, load_year, load_month, load_date, day_in,
        input  cmd_out, data_out, year, month, date, day_of_week,
               dow_valid, busy, load_err
    );

    modport slave (
        input  day_tick, load, load_year, load_month, load_date, day_in,
        output cmd_out, data_out, year, month, date, day_of_week,
               dow_valid, busy, load_err
    );
endinterface

// File: rtl/calendar_date_feeder_date_reg.sv
// calendar_date_reg: holds the current year/month/date, validates loads and
// advances one day per tick, wrapping YEAR_MAX-12-31 to YEAR_MIN-01-01.
//   clk, reset          : clock, async active-high reset
//   day_tick, load      : one-cycle requests (load wins when both are high)
//   load_year/month/date: candidate date for load
//   year, month, date   : current date (registered)
//   load_err            : one-cycle pulse after a rejected load
//   update              : combinational, high in the cycle an update is accepted
module calendar_date_reg
    import calendar_date_feeder_pkg::*;
#(
    parameter logic [15:0] YEAR_MIN     = 16'd1900,
    parameter logic [15:0] YEAR_MAX     = 16'd2019,
    parameter logic [15:0] RESET_YEAR   = 16'd2000,
    parameter logic [15:0] RESET_MONTH  = 16'd1,
    parameter logic [15:0] RESET_DATE   = 16'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        day_tick,
    input  logic        load,
    input  logic [15:0] load_year,
    input  logic [15:0] load_month,
    input  logic [15:0] load_date,
    output logic [15:0] year,
    output logic [15:0] month,
    output logic [15:0] date,
    output logic        load_err,
    output logic        update
);

    logic [15:0] dim_cur;
    logic [15:0] dim_load;
    logic        load_ok;

    assign dim_cur  = {11'd0, days_in_month(year, month)};
    assign dim_load = {11'd0, days_in_month(load_year, load_month)};

    assign load_ok = (load_year  >= YEAR_MIN) && (load_year  <= YEAR_MAX) &&
                     (load_month >= 16'd1)    && (load_month <= 16'd12)   &&
                     (load_date  >= 16'd1)    && (load_date  <= dim_load);

    // A load request masks a same-cycle tick even when the load is rejected.
    assign update = (load && load_ok) || (!load && day_tick);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            year     <= RESET_YEAR;
            month    <= RESET_MONTH;
            date     <= RESET_DATE;
            load_err <= 1'b0;
        end else begin
            load_err <= load && !load_ok;
            if (load) begin
                if (load_ok) begin
                    year  <= load_year;
                    month <= load_month;
                    date  <= load_date;
                end
            end else if (day_tick) begin
                if (date < dim_cur) begin
                    date <= date + 16'd1;
                end else begin
                    date <= 16'd1;
                    if (month < 16'd12) begin
                        month <= month + 16'd1;
                    end else begin
                        month <= 16'd1;
                        year  <= (year >= YEAR_MAX) ? YEAR_MIN : year + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/calendar_date_feeder.sv
// calendar_date_feeder: keeps the calendar date and, after every change,
// writes year/month/date to the day stage, reads the day code back and
// registers it for software.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of calendar_date_feeder_if (requests in, command
//                bus / date / day_of_week / dow_valid / busy / load_err out)
module calendar_date_feeder
    import calendar_date_feeder_pkg::*;
#(
    parameter logic [15:0] YEAR_MIN      = 16'd1900,
    parameter logic [15:0] YEAR_MAX      = 16'd2019,
    parameter logic [15:0] RESET_YEAR    = 16'd2000,
    parameter logic [15:0] RESET_MONTH   = 16'd1,
    parameter logic [15:0] RESET_DATE    = 16'd1,
    parameter int          SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    calendar_date_feeder_if.slave bus
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state, state_nx;
    logic [7:0]  settle_cnt;
    logic        pending;
    logic        update;
    logic [15:0] day_hold;
    logic [2:0]  dow_q;
    logic        dow_valid_q;
    logic [15:0] year, month, date;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        busy;

    calendar_date_reg #(
        .YEAR_MIN    (YEAR_MIN),
        .YEAR_MAX    (YEAR_MAX),
        .RESET_YEAR  (RESET_YEAR),
        .RESET_MONTH (RESET_MONTH),
        .RESET_DATE  (RESET_DATE)
    ) u_date (
        .clk        (clk),
        .reset      (reset),
        .day_tick   (bus.day_tick),
        .load       (bus.load),
        .load_year  (bus.load_year),
        .load_month (bus.load_month),
        .load_date  (bus.load_date),
        .year       (year),
        .month      (month),
        .date       (date),
        .load_err   (bus.load_err),
        .update     (update)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // day_in is latched on the last read cycle (the edge entering CAPTURE);
    // the result is published on the edge leaving CAPTURE. An update on any
    // edge wins over a capture on that same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt  <= 8'd0;
            pending     <= 1'b1;
            day_hold    <= 16'd0;
            dow_q       <= 3'd0;
            dow_valid_q <= 1'b0;
        end else begin
            settle_cnt <= (state == RD_DAY) ? settle_cnt + 8'd1 : 8'd0;
            if (state == RD_DAY && settle_cnt == SETTLE_LAST)
                day_hold <= bus.day_in;
            if (update) begin
                pending     <= 1'b1;
                dow_valid_q <= 1'b0;
            end else begin
                if (state == IDLE && pending)
                    pending <= 1'b0;
                if (state == CAPTURE) begin
                    if (!pending && day_hold <= 16'd6) begin
                        dow_q       <= day_hold[2:0];
                        dow_valid_q <= 1'b1;
                    end else begin
                        dow_valid_q <= 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        cmd      = CMD_NONE;
        data     = 16'd0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (pending) state_nx = WR_YEAR;
            end
            WR_YEAR: begin
                cmd      = CMD_WR_YEAR;
                data     = year;
                state_nx = WR_MONTH;
            end
            WR_MONTH: begin
                cmd      = CMD_WR_MONTH;
                data     = month;
                state_nx = WR_DATE;
            end
            WR_DATE: begin
                cmd      = CMD_WR_DATE;
                data     = date;
                state_nx = RD_DAY;
            end
            RD_DAY: begin
                cmd = CMD_RD_DAY;
                if (settle_cnt == SETTLE_LAST) state_nx = CAPTURE;
            end
            CAPTURE: state_nx = IDLE;
            default: begin
                busy     = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.cmd_out     = cmd;
    assign bus.data_out    = data;
    assign bus.busy        = busy;
    assign bus.year        = year;
    assign bus.month       = month;
    assign bus.date        = date;
    assign bus.day_of_week = dow_q;
    assign bus.dow_valid   = dow_valid_q;

endmodule

// File: tb/tb_calendar_date_feeder.sv
// Directed bench for calendar_date_feeder with a behavioural day stage that
// latches written fields and answers reads with a day code (2000-01-01 = 0).
module tb_calendar_date_feeder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    calendar_date_feeder_if bus();
    calendar_date_feeder dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Day code: Sakamoto weekday (0=Sunday) shifted so Saturday = 0.
    function automatic logic [2:0] dow_code(input int y, input int m, input int d);
        int t, yy, s;
        case (m)
            1: t = 0;  2: t = 3;  3: t = 2;  4: t = 5;
            5: t = 0;  6: t = 3;  7: t = 5;  8: t = 1;
            9: t = 4;  10: t = 6; 11: t = 2; default: t = 4;
        endcase
        yy = (m < 3) ? y - 1 : y;
        s  = (yy + yy / 4 - yy / 100 + yy / 400 + t + d) % 7;
        return 3'((s + 1) % 7);
    endfunction

    logic        ret_bad = 1'b0;
    logic [15:0] ds_y = 16'd0, ds_m = 16'd1, ds_d = 16'd1;
    always @(posedge clk) begin
        case (bus.cmd_out)
            8'h05: ds_y <= bus.data_out;
            8'h09: ds_m <= bus.data_out;
            8'h0D: ds_d <= bus.data_out;
            default: ;
        endcase
    end
    always_comb begin
        bus.day_in = 16'h0000;
        if (bus.cmd_out == 8'h03)
            bus.day_in = ret_bad ? 16'hFFFF : {13'd0, dow_code(int'(ds_y), int'(ds_m), int'(ds_d))};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_date(input string nm, input int y, input int m, input int d);
        chk({nm, " year"},  bus.year,  y);
        chk({nm, " month"}, bus.month, m);
        chk({nm, " date"},  bus.date,  d);
    endtask

    // Reset is high on entry; releases it and follows the auto-started sequence.
    task automatic reset_seq(input string tag);
        @(posedge clk); #1;
        reset = 1'b0;
        chk_date({tag, " rst"}, 2000, 1, 1);
        chk({tag, " rst cmd"},  bus.cmd_out, 8'h00);
        chk({tag, " rst busy"}, bus.busy, 0);
        chk({tag, " rst dowv"}, bus.dow_valid, 0);
        chk({tag, " rst dow"},  bus.day_of_week, 0);
        chk({tag, " rst err"},  bus.load_err, 0);
        step(); chk({tag, " cmd1"}, bus.cmd_out, 8'h05); chk({tag, " data1"}, bus.data_out, 16'h07D0);
        chk({tag, " busy1"}, bus.busy, 1);
        step(); chk({tag, " cmd2"}, bus.cmd_out, 8'h09); chk({tag, " data2"}, bus.data_out, 1);
        step(); chk({tag, " cmd3"}, bus.cmd_out, 8'h0D); chk({tag, " data3"}, bus.data_out, 1);
        step(); chk({tag, " cmd4"}, bus.cmd_out, 8'h03);
        step(); chk({tag, " cmd5"}, bus.cmd_out, 8'h03);
        step(); chk({tag, " cmd6"}, bus.cmd_out, 8'h00); chk({tag, " dowv6"}, bus.dow_valid, 0);
        chk({tag, " busy6"}, bus.busy, 1);
        step(); chk({tag, " dowv7"}, bus.dow_valid, 1); chk({tag, " dow7"}, bus.day_of_week, 0);
        chk({tag, " busy7"}, bus.busy, 0);
    endtask

    // Counts edges until dow_valid rises (bounded); n is edges already elapsed.
    task automatic wait_dow(input string nm, input int n0, input int exp_n, input int y, input int m, input int d);
        int n;
        n = n0;
        while (!bus.dow_valid && n < 30) begin
            step();
            n++;
        end
        chk({nm, " latency"}, n, exp_n);
        chk({nm, " dow"}, bus.day_of_week, dow_code(y, m, d));
        chk({nm, " busy"}, bus.busy, 0);
    endtask

    typedef struct {
        logic        ld;
        logic        tk;
        logic [15:0] ly, lm, ldd;
        logic [15:0] ey, em, ed;
        logic        err;
    } vec_t;

    vec_t vecs[15];

    initial begin
        bus.day_tick   = 1'b0;
        bus.load       = 1'b0;
        bus.load_year  = 16'd0;
        bus.load_month = 16'd0;
        bus.load_date  = 16'd0;

        vecs[0]  = '{1'b1, 1'b0, 16'd2016, 16'd2,  16'd28, 16'd2016, 16'd2,  16'd28, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 16'd0,    16'd0,  16'd0,  16'd2016, 16'd2,  16'd29, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 16'd0,    16'd0,  16'd0,  16'd2016, 16'd3,  16'd1,  1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'd1900, 16'd2,  16'd28, 16'd1900, 16'd2,  16'd28, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'd0,    16'd0,  16'd0,  16'd1900, 16'd3,  16'd1,  1'b0};
        vecs[5]  = '{1'b1, 1'b0, 16'd2019, 16'd12, 16'd31, 16'd2019, 16'd12, 16'd31, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 16'd0,    16'd0,  16'd0,  16'd1900, 16'd1,  16'd1,  1'b0};
        vecs[7]  = '{1'b1, 1'b0, 16'd2019, 16'd4,  16'd30, 16'd2019, 16'd4,  16'd30, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 16'd0,    16'd0,  16'd0,  16'd2019, 16'd5,  16'd1,  1'b0};
        vecs[9]  = '{1'b1, 1'b0, 16'd2000, 16'd13, 16'd5,  16'd2019, 16'd5,  16'd1,  1'b1};
        vecs[10] = '{1'b1, 1'b0, 16'd1900, 16'd2,  16'd29, 16'd2019, 16'd5,  16'd1,  1'b1};
        vecs[11] = '{1'b1, 1'b0, 16'd2020, 16'd1,  16'd1,  16'd2019, 16'd5,  16'd1,  1'b1};
        vecs[12] = '{1'b1, 1'b1, 16'd1899, 16'd12, 16'd31, 16'd2019, 16'd5,  16'd1,  1'b1};
        vecs[13] = '{1'b1, 1'b0, 16'd2000, 16'd2,  16'd29, 16'd2000, 16'd2,  16'd29, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 16'd2010, 16'd6,  16'd15, 16'd2010, 16'd6,  16'd15, 1'b0};

        repeat (3) @(posedge clk);
        reset_seq("boot");

        for (int i = 0; i < 15; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            bus.load       = vecs[i].ld;
            bus.day_tick   = vecs[i].tk;
            bus.load_year  = vecs[i].ly;
            bus.load_month = vecs[i].lm;
            bus.load_date  = vecs[i].ldd;
            step();
            bus.load     = 1'b0;
            bus.day_tick = 1'b0;
            chk_date(nm, vecs[i].ey, vecs[i].em, vecs[i].ed);
            chk({nm, " err"}, bus.load_err, vecs[i].err);
            if (vecs[i].err) begin
                chk({nm, " dowv kept"}, bus.dow_valid, 1);
                step();
                chk({nm, " err pulse"}, bus.load_err, 0);
                chk({nm, " no seq"}, bus.busy, 0);
                chk({nm, " dowv kept2"}, bus.dow_valid, 1);
            end else begin
                chk({nm, " dowv clr"}, bus.dow_valid, 0);
                wait_dow(nm, 0, 7, vecs[i].ey, vecs[i].em, vecs[i].ed);
            end
        end

        // Tick while reading: first result dropped, second sequence follows.
        bus.day_tick = 1'b1; step(); bus.day_tick = 1'b0;
        chk_date("rdtick a", 2010, 6, 16);
        repeat (4) step();
        chk("rdtick in rd", bus.cmd_out, 8'h03);
        bus.day_tick = 1'b1; step(); bus.day_tick = 1'b0;
        chk_date("rdtick b", 2010, 6, 17);
        chk("rdtick dowv5", bus.dow_valid, 0);
        step(); step();
        chk("rdtick idle cmd", bus.cmd_out, 8'h00);
        chk("rdtick idle busy", bus.busy, 0);
        chk("rdtick discard", bus.dow_valid, 0);
        step();
        chk("rdtick restart", bus.cmd_out, 8'h05);
        chk("rdtick restart data", bus.data_out, 16'd2010);
        wait_dow("rdtick", 8, 14, 2010, 6, 17);

        // Out-of-range day code from the day stage is ignored.
        ret_bad = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            bus.day_tick = 1'b1; step(); bus.day_tick = 1'b0;
            repeat (10) begin
                step();
                if (bus.dow_valid) seen = 1'b1;
            end
            chk("bad code dowv", seen, 0);
            chk("bad code busy", bus.busy, 0);
        end
        ret_bad = 1'b0;

        // Reset in the middle of a read.
        bus.day_tick = 1'b1; step(); bus.day_tick = 1'b0;
        repeat (4) step();
        chk("midrst rd", bus.cmd_out, 8'h03);
        #2 reset = 1'b1;
        #1;
        chk("midrst cmd", bus.cmd_out, 8'h00);
        chk("midrst busy", bus.busy, 0);
        chk("midrst year", bus.year, 2000);
        chk("midrst dowv", bus.dow_valid, 0);
        reset_seq("replay");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
